// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, width helper and byte-lane merge for the banked data memory.
package dmem_pkg;
    typedef enum logic {IDLE, RMW_WR} state_e;
    localparam int MAX_W = 512;
    localparam int MAX_NB = MAX_W / 8;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin end
        return r;
    endfunction
    // Lanes with be set take the new data; the rest keep the stored word.
    function automatic logic [MAX_W-1:0] merge_lanes(input logic [MAX_W-1:0] old_w,
                                                     input logic [MAX_W-1:0] new_w,
                                                     input logic [MAX_NB-1:0] be);
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_NB; i++) m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one single-port bank with a one-cycle registered read; uses the SRAM macro when it fits.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    if (DEPTH == 256 && DATA_W == 32) begin : g_macro
        fakeram7_256x32 u_ram (
            .clk(clk), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
            .wd_in(wdata_i), .w_mask_in('1), .rd_out(rdata_o)
        );
    end else begin : g_beh
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (ce_i) begin
                if (we_i) mem[addr_i] <= wdata_i;
                else rd_q <= mem[addr_i];
            end
        end
        assign rdata_o = rd_q;
    end
endmodule

// File: rtl/fakeram7_256x32.sv
// fakeram7_256x32: behavioural stand-in for the 256x32 SRAM macro, registered read output.
module fakeram7_256x32 (
    input  logic        clk,
    input  logic        ce_in,
    input  logic        we_in,
    input  logic [7:0]  addr_in,
    input  logic [31:0] wd_in,
    input  logic [31:0] w_mask_in,
    output logic [31:0] rd_out
);
    logic [31:0] mem [256];
    always_ff @(posedge clk) begin
        if (ce_in) begin
            if (we_in) mem[addr_in] <= (wd_in & w_mask_in) | (mem[addr_in] & ~w_mask_in);
            else rd_out <= mem[addr_in];
        end
    end
endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: N-bank data memory with byte-enable RMW writes, range/alignment errors and
// in-order responses one edge after the bank access.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 256,
    parameter int INTERLEAVE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int BO = clog2(NB);
    localparam int BW = clog2(NUM_BANKS);
    localparam int BI = (BW > 0) ? BW : 1;
    localparam int RW = clog2(BANK_DEPTH);
    localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(NUM_BANKS * BANK_DEPTH);

    state_e state_q;
    logic pend_v_q, pend_rd_q, pend_err_q, rsp_valid_q, rsp_err_q;
    logic [BI-1:0] pend_bank_q, bank_q, bank;
    logic [RW-1:0] row_q, row, addr;
    logic [DATA_W-1:0] wdata_q, rsp_rdata_q, wd, merged_d;
    logic [NB-1:0] be_q;
    logic [ADDR_W-1:0] w;
    logic [NUM_BANKS-1:0] ce;
    logic [DATA_W-1:0] rd [NUM_BANKS];
    logic err, be_full, be_zero, acc, partial, we;

    assign w = req_addr >> BO;
    assign bank = (NUM_BANKS == 1) ? '0 : (INTERLEAVE != 0) ? BI'(w) : BI'(w >> RW);
    assign row = (INTERLEAVE != 0) ? RW'(w >> BW) : RW'(w);
    assign err = ((req_addr & ADDR_W'(NB - 1)) != '0) || (w >= WORDS);
    assign be_full = &req_be;
    assign be_zero = ~|req_be;
    // Holding ready low through reset keeps the banks untouched until rst_n releases.
    assign req_ready = rst_n && state_q == IDLE;
    assign acc = req_valid && req_ready;
    assign partial = acc && req_we && !err && !be_full && !be_zero;
    assign merged_d = DATA_W'(merge_lanes(MAX_W'(rd[bank_q]), MAX_W'(wdata_q), MAX_NB'(be_q)));

    always_comb begin
        ce = '0;
        we = 1'b0;
        addr = row;
        wd = req_wdata;
        if (state_q == RMW_WR) begin
            ce[bank_q] = 1'b1;
            we = 1'b1;
            addr = row_q;
            wd = merged_d;
        end else if (acc && !err && !(req_we && be_zero)) begin
            ce[bank] = 1'b1;
            we = req_we && be_full;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dmem_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH)) u_bank (
            .clk(clk), .ce_i(ce[b]), .we_i(we && ce[b]), .addr_i(addr),
            .wdata_i(wd), .rdata_o(rd[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_v_q <= 1'b0;
            pend_rd_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_bank_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_rdata_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            bank_q <= '0;
            row_q <= '0;
        end else begin
            pend_v_q <= (acc && !partial) || state_q == RMW_WR;
            pend_rd_q <= acc && !req_we && !err;
            pend_err_q <= acc && err;
            pend_bank_q <= bank;
            rsp_valid_q <= pend_v_q;
            rsp_err_q <= pend_err_q;
            rsp_rdata_q <= pend_rd_q ? rd[pend_bank_q] : '0;
            state_q <= partial ? RMW_WR : IDLE;
            if (partial) begin
                wdata_q <= req_wdata;
                be_q <= req_be;
                bank_q <= bank;
                row_q <= row;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: directed and random requests against a word-array reference model with
// per-response timing, ordering, error and data checks.
module tb_dmem_banked;
    logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_be = '0;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_banked dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {int due; bit err; bit known; logic [31:0] data;} exp_t;
    exp_t q[$];
    logic [31:0] mem_m [int];
    int cyc = 0, checks = 0, errors = 0, pend_idx = 0;
    bit pend_ok = 1'b0;
    logic [31:0] pend_val = '0, last_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Words live in a 1024-entry space; a partial write only lands if no reset hits before its write cycle.
    task automatic model_accept(output bit partial);
        int idx;
        bit err;
        exp_t e;
        logic [31:0] old, nw;
        idx = int'(req_addr >> 2);
        err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'd4096);
        e.due = cyc + 2;
        e.err = err;
        e.known = 1'b1;
        e.data = '0;
        partial = 1'b0;
        if (!err && !req_we) begin
            e.known = mem_m.exists(idx);
            e.data = e.known ? mem_m[idx] : '0;
        end else if (!err && req_we && req_be != 4'h0) begin
            old = mem_m.exists(idx) ? mem_m[idx] : '0;
            for (int i = 0; i < 4; i++) nw[8*i +: 8] = req_be[i] ? req_wdata[8*i +: 8] : old[8*i +: 8];
            if (req_be == 4'hF) mem_m[idx] = nw;
            else begin
                partial = 1'b1;
                e.due = cyc + 3;
                pend_ok = 1'b1;
                pend_idx = idx;
                pend_val = nw;
            end
        end
        q.push_back(e);
    endtask

    task automatic step(output bit acc);
        bit part;
        part = 1'b0;
        if (pend_ok) begin
            mem_m[pend_idx] = pend_val;
            pend_ok = 1'b0;
        end
        acc = req_valid && req_ready;
        if (acc) model_accept(part);
        @(posedge clk);
        #1;
        cyc++;
        chk("req_ready", 32'(req_ready), 32'(!part));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
            if (q[0].known) chk("rsp_rdata", rsp_rdata, q[0].data);
            last_rdata = rsp_rdata;
            void'(q.pop_front());
        end else chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit acc;
        acc = 1'b0;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_be = be;
        for (int k = 0; k < 4 && !acc; k++) step(acc);
        req_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        q.delete();
        pend_ok = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 64; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);
        idle(2);
        // Reset while a read response is in flight drops it.
        issue(1'b0, 32'h20, '0, '0);
        do_reset();
        idle(2);
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h4, '0, '0);
        idle(2);
        chk("full_write_read", last_rdata, 32'hDEADBEEF);
        issue(1'b1, 32'h8, 32'h11223344, 4'hF);
        issue(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 32'h8, '0, '0);
        idle(2);
        chk("partial_merge", last_rdata, 32'h11BB33DD);
        for (int i = 0; i < 4; i++) issue(1'b1, 32'(i * 4), 32'hB0B0_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), '0, '0);
        idle(3);
        chk("bank3_last", last_rdata, 32'hB0B0_0003);
        issue(1'b0, 32'h2, '0, '0);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF);
        issue(1'b0, 32'h0, '0, '0);
        idle(2);
        chk("oor_no_alias", last_rdata, 32'hB0B0_0000);
        issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0001);
        do_reset();
        issue(1'b0, 32'h10, '0, '0);
        idle(2);
        chk("rmw_reset_drop", last_rdata, 32'hCAFEF00D);
        repeat (300) begin
            r = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 63)) << 2;
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
